// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared definitions for the UART command-frame parser.
//               Holds the parser state encoding, the error-code constants,
//               the default start-of-frame marker and a length-check helper.
// Ports       : (package, no ports)
// Config      : UART_CMD_CHECKSUM_EN (consumed by uart_cmd_parser)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Parser states. ST_CSUM is only reachable when the checksum byte is
    // part of the frame.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Error codes reported on o_Err_Code alongside o_Err_Pulse.
    localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
    localparam logic [1:0] ERR_BAD_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_OVERRUN  = 2'b11;

    // Default start-of-frame marker.
    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // A length byte is acceptable when it is non-zero and fits the buffer.
    function automatic logic len_ok(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/uart_cmd_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_buf
// Description : Payload storage for the command parser. DEPTH x 8 bits,
//               one synchronous write port, one asynchronous read port.
//               Contents are deliberately not reset.
// Ports       : clk      - write clock (rising edge)
//               wr_en    - write strobe
//               wr_addr  - write index
//               wr_data  - write byte
//               rd_addr  - read index
//               rd_data  - byte at rd_addr (combinational; 0 when out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // The address range can exceed DEPTH when DEPTH is not a power of two,
    // so both ports are guarded against out-of-range indices.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule : uart_cmd_buf
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Assembles command frames from a UART byte stream.
//               Frame: SOF, LEN, LEN payload bytes [, CSUM]
//               CSUM = XOR of LEN and all payload bytes.
//               A complete frame is held (o_Cmd_Valid) until the consumer
//               pulses i_Cmd_Ready; payload is read through i_Rd_Addr.
// Ports       : i_Clock     - clock, rising edge
//               i_Reset     - asynchronous active-low reset
//               i_Rx_DV     - one-cycle byte strobe from the UART receiver
//               i_Rx_Byte   - received byte
//               o_Cmd_Valid - frame held and readable
//               i_Cmd_Ready - consumer releases the held frame
//               o_Cmd_Len   - payload length of the held frame
//               i_Rd_Addr   - payload read index
//               o_Rd_Data   - payload byte at i_Rd_Addr (combinational)
//               o_Err_Pulse - one-cycle error strobe
//               o_Err_Code  - 00 timeout, 01 bad length, 10 checksum,
//                             11 overrun (valid while o_Err_Pulse is high)
// Config      : UART_CMD_CHECKSUM_EN - when defined the frame carries a
//               trailing checksum byte that is verified; when undefined the
//               frame ends after the last payload byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter  int         MAX_LEN      = 16,
    parameter  logic [7:0] SOF_BYTE     = DEFAULT_SOF,
    parameter  int         TIMEOUT_CLKS = 3480,
    // Read index width; kept at least one bit so MAX_LEN=1 still elaborates.
    localparam int         ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Cmd_Valid,
    input  logic              i_Cmd_Ready,
    output logic [7:0]        o_Cmd_Len,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Err_Pulse,
    output logic [1:0]        o_Err_Code
);

    // Gap counter wide enough to hold TIMEOUT_CLKS.
    localparam int               GAP_W    = $clog2(TIMEOUT_CLKS + 1);
    // The timeout fires on the idle edge that would bring the count to
    // TIMEOUT_CLKS, i.e. when the registered count already equals
    // TIMEOUT_CLKS-1 and no byte arrives.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state,     state_nxt;
    logic [7:0]         cmd_len,   cmd_len_nxt;
    logic [7:0]         idx,       idx_nxt;
    logic [GAP_W-1:0]   gap_cnt,   gap_cnt_nxt;
    logic               err_pulse, err_pulse_nxt;
    logic [1:0]         err_code,  err_code_nxt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]         csum,      csum_nxt;
`endif

    logic               buf_we;
    logic [ADDR_W-1:0]  buf_waddr;
    logic [7:0]         idx_inc;
    logic               sof_hit;
    logic               in_frame;

    assign idx_inc   = idx + 8'd1;
    assign sof_hit   = i_Rx_DV && (i_Rx_Byte == SOF_BYTE);
    assign in_frame  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign buf_waddr = idx[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state     <= ST_IDLE;
            cmd_len   <= 8'd0;
            idx       <= 8'd0;
            gap_cnt   <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_TIMEOUT;
`ifdef UART_CMD_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            cmd_len   <= cmd_len_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_cnt_nxt;
            err_pulse <= err_pulse_nxt;
            err_code  <= err_code_nxt;
`ifdef UART_CMD_CHECKSUM_EN
            csum      <= csum_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        cmd_len_nxt   = cmd_len;
        idx_nxt       = idx;
        gap_cnt_nxt   = gap_cnt;
        err_pulse_nxt = 1'b0;
        err_code_nxt  = err_code;
        buf_we        = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_nxt      = csum;
`endif

        case (state)
            ST_IDLE: begin
                if (sof_hit) begin
                    state_nxt   = ST_LEN;
                    gap_cnt_nxt = '0;
                end
            end

            ST_LEN: begin
                if (i_Rx_DV) begin
                    if (len_ok(i_Rx_Byte, MAX_LEN)) begin
                        state_nxt   = ST_DATA;
                        cmd_len_nxt = i_Rx_Byte;
                        idx_nxt     = 8'd0;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_nxt    = i_Rx_Byte;
`endif
                    end else begin
                        state_nxt     = ST_IDLE;
                        err_pulse_nxt = 1'b1;
                        err_code_nxt  = ERR_BAD_LEN;
                    end
                end
            end

            ST_DATA: begin
                if (i_Rx_DV) begin
                    buf_we  = 1'b1;
                    idx_nxt = idx_inc;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_nxt = csum ^ i_Rx_Byte;
                    if (idx_inc == cmd_len) begin
                        state_nxt = ST_CSUM;
                    end
`else
                    if (idx_inc == cmd_len) begin
                        state_nxt = ST_HOLD;
                    end
`endif
                end
            end

`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == csum) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt     = ST_IDLE;
                        err_pulse_nxt = 1'b1;
                        err_code_nxt  = ERR_CHECKSUM;
                    end
                end
            end
`endif

            ST_HOLD: begin
                // A release and a new byte in the same cycle: the release
                // wins and the byte is treated exactly as in IDLE.
                if (i_Cmd_Ready) begin
                    if (sof_hit) begin
                        state_nxt   = ST_LEN;
                        gap_cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (i_Rx_DV) begin
                    err_pulse_nxt = 1'b1;
                    err_code_nxt  = ERR_OVERRUN;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Inter-byte gap supervision. A timeout can only occur on a cycle
        // without a byte, so it never collides with another error source.
        if (in_frame) begin
            if (i_Rx_DV) begin
                gap_cnt_nxt = '0;
            end else if (gap_cnt == GAP_LAST) begin
                state_nxt     = ST_IDLE;
                gap_cnt_nxt   = '0;
                err_pulse_nxt = 1'b1;
                err_code_nxt  = ERR_TIMEOUT;
            end else begin
                gap_cnt_nxt = gap_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload storage
    // ------------------------------------------------------------------
    uart_cmd_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_data (i_Rx_Byte),
        .rd_addr (i_Rd_Addr),
        .rd_data (o_Rd_Data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_Cmd_Valid = (state == ST_HOLD);
    assign o_Cmd_Len   = cmd_len;
    assign o_Err_Pulse = err_pulse;
    assign o_Err_Code  = err_code;

endmodule : uart_cmd_parser
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser. A frame-level
//               reference model (byte queue per frame) predicts o_Cmd_Valid,
//               o_Cmd_Len, o_Rd_Data and the error strobe every cycle;
//               directed scenarios add hand-computed literal checks.
//               A small bench-side serial transmitter/receiver pair drives
//               the parser from a serial line for the integration case.
// Config      : honours UART_CMD_CHECKSUM_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 3480;
    localparam int         CPB     = 87;
    localparam logic [7:0] SOF     = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int         CS      = 1;
`else
    localparam int         CS      = 0;
`endif

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv, ready;
    logic [7:0] rx_byte;
    logic [3:0] rd_addr;
    logic       serial = 1'b1;
    logic       uart_mode = 1'b0;
    logic       u_dv = 1'b0;
    logic [7:0] u_byte = 8'h00;
    logic       dut_dv;
    logic [7:0] dut_byte;
    logic       o_valid, o_err;
    logic [7:0] o_len, o_data;
    logic [1:0] o_code;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;
    int last_code = 0;

    assign dut_dv   = uart_mode ? u_dv   : rx_dv;
    assign dut_byte = uart_mode ? u_byte : rx_byte;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .MAX_LEN      (MAX_LEN),
        .SOF_BYTE     (SOF),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst_n),
        .i_Rx_DV     (dut_dv),
        .i_Rx_Byte   (dut_byte),
        .o_Cmd_Valid (o_valid),
        .i_Cmd_Ready (ready),
        .o_Cmd_Len   (o_len),
        .i_Rd_Addr   (rd_addr),
        .o_Rd_Data   (o_data),
        .o_Err_Pulse (o_err),
        .o_Err_Code  (o_code)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects the bytes after SOF and judges the frame
    // by its length and content once enough bytes are present.
    // ------------------------------------------------------------------
    logic [7:0] m_frame[$];
    logic [7:0] m_payload[$];
    bit         m_active = 0;
    bit         m_held   = 0;
    bit         m_err    = 0;
    int         m_code   = 0;
    int         m_len    = 0;
    int         m_gap    = 0;

    always @(posedge clk) begin
        m_err = 0;
        if (!rst_n) begin
            m_active = 0; m_held = 0; m_gap = 0; m_frame.delete();
        end else if (m_held) begin
            if (ready) begin
                m_held = 0;
                if (dut_dv && dut_byte == SOF) begin
                    m_active = 1; m_gap = 0; m_frame.delete();
                end
            end else if (dut_dv) begin
                m_err = 1; m_code = 3;
            end
        end else if (!m_active) begin
            if (dut_dv && dut_byte == SOF) begin
                m_active = 1; m_gap = 0; m_frame.delete();
            end
        end else if (dut_dv) begin
            int n;
            m_gap = 0;
            m_frame.push_back(dut_byte);
            n = int'(m_frame[0]);
            if (m_frame.size() == 1 && (n == 0 || n > MAX_LEN)) begin
                m_err = 1; m_code = 1; m_active = 0;
            end else if (m_frame.size() == n + 1 + CS) begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 0; i <= n; i++) x = x ^ m_frame[i];
                m_active = 0;
                if (CS == 1 && x != m_frame[n + 1]) begin
                    m_err = 1; m_code = 2;
                end else begin
                    m_held = 1; m_len = n;
                    m_payload.delete();
                    for (int i = 1; i <= n; i++) m_payload.push_back(m_frame[i]);
                end
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                m_err = 1; m_code = 0; m_active = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", o_valid, 0);
            check("rst_len", o_len, 0);
            check("rst_err", o_err, 0);
            check("rst_code", o_code, 0);
        end else begin
            check("valid", o_valid, m_held);
            check("err_pulse", o_err, m_err);
            if (m_err) check("err_code", o_code, m_code);
            if (m_held) begin
                check("len", o_len, m_len);
                if (int'(rd_addr) < m_len) check("rd_data", o_data, m_payload[rd_addr]);
            end
        end
        if (o_err) begin
            err_cnt++;
            last_code = o_code;
        end
    end

    // Bench-side UART receiver: mid-bit sampling, 8N1, LSB first.
    always begin
        @(posedge clk);
        if (uart_mode && !serial) begin
            repeat (CPB / 2) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clk);
                u_byte[b] = serial;
            end
            repeat (CPB) @(posedge clk);
            #1 u_dv = 1'b1;
            @(posedge clk);
            #1 u_dv = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        tick();
        rx_dv = 1'b0;
        tick();
    endtask

    task automatic send_q(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    // Checksum byte is part of the frame only in the checksum build.
    task automatic send_cs(input logic [7:0] b);
        if (CS == 1) send(b);
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input int exp);
        rd_addr = a;
        #1;
        check(name, o_data, exp);
    endtask

    task automatic release_frame(input string name);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check(name, o_valid, 0);
    endtask

    task automatic uart_tx(input logic [7:0] b);
        serial = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            repeat (CPB) tick();
        end
        serial = 1'b1;
        repeat (CPB) tick();
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int e0;
        int k;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; ready = 1'b0; rd_addr = 4'd0;
        repeat (3) tick();
        check("reset_valid", o_valid, 0);
        check("reset_len", o_len, 0);
        check("reset_err", o_err, 0);
        rst_n = 1'b1;
        tick();

        // Good frame A5 03 11 22 33 [03]
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
        send_cs(8'h03);
        check("good_valid", o_valid, 1);
        check("good_len", o_len, 3);
        read_check("good_rd0", 4'd0, 8'h11);
        read_check("good_rd1", 4'd1, 8'h22);
        read_check("good_rd2", 4'd2, 8'h33);
        release_frame("good_release");

        // Wrong checksum byte (or, without checksum, a byte into a held frame)
        e0 = err_cnt;
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
        send(8'h04);
        check("bad_tail_errs", err_cnt, e0 + 1);
        check("bad_tail_code", last_code, (CS == 1) ? 2 : 3);
        check("bad_tail_valid", o_valid, (CS == 1) ? 0 : 1);
        if (CS == 0) release_frame("bad_tail_release");

        // Bad lengths, then a good frame A5 02 AA 55 [FD]
        e0 = err_cnt;
        send_q('{8'hA5, 8'h00});
        check("len0_errs", err_cnt, e0 + 1);
        check("len0_code", last_code, 1);
        send_q('{8'hA5, 8'h11});
        check("len17_errs", err_cnt, e0 + 2);
        check("len17_code", last_code, 1);
        send_q('{8'hA5, 8'h02, 8'hAA, 8'h55});
        send_cs(8'hFD);
        check("after_len_valid", o_valid, 1);
        check("after_len_len", o_len, 2);
        read_check("after_len_rd1", 4'd1, 8'h55);
        release_frame("after_len_release");

        // Timeout: A5 02 7E, then silence
        send_q('{8'hA5, 8'h02});
        rx_dv = 1'b1; rx_byte = 8'h7E;
        tick();
        rx_dv = 1'b0;
        k = 0;
        while (!o_err && k < TIMEOUT + 20) begin
            tick();
            k++;
        end
        check("timeout_gap", k, TIMEOUT);
        check("timeout_code", o_code, 0);
        tick();
        e0 = err_cnt;
        send(8'h7F);
        check("idle_7f_errs", err_cnt, e0);
        check("idle_7f_valid", o_valid, 0);
        repeat (TIMEOUT + 10) tick();
        check("idle_no_timeout", err_cnt, e0);

        // Overrun and release/SOF in the same cycle
        send_q('{8'hA5, 8'h01, 8'h10});
        send_cs(8'h11);
        check("ovr_held", o_valid, 1);
        e0 = err_cnt;
        send(8'h55);
        check("ovr_errs", err_cnt, e0 + 1);
        check("ovr_code", last_code, 3);
        check("ovr_still_valid", o_valid, 1);
        e0 = err_cnt;
        ready = 1'b1; rx_dv = 1'b1; rx_byte = 8'hA5;
        tick();
        ready = 1'b0; rx_dv = 1'b0;
        tick();
        check("simul_no_err", err_cnt, e0);
        check("simul_released", o_valid, 0);
        send_q('{8'h01, 8'h40});
        send_cs(8'h41);
        check("simul_valid", o_valid, 1);
        check("simul_len", o_len, 1);
        read_check("simul_rd0", 4'd0, 8'h40);
        release_frame("simul_release");

        // Reset mid-frame discards the partial frame silently
        e0 = err_cnt;
        send_q('{8'hA5, 8'h03, 8'h11});
        rst_n = 1'b0;
        repeat (2) tick();
        check("midrst_errs", err_cnt, e0);
        check("midrst_valid", o_valid, 0);
        rst_n = 1'b1;
        tick();
        send_q('{8'hA5, 8'h01, 8'h77});
        send_cs(8'h76);
        check("postrst_valid", o_valid, 1);
        read_check("postrst_rd0", 4'd0, 8'h77);
        release_frame("postrst_release");

        // Serial path: A5 01 3F 3E through the bench UART receiver
        uart_mode = 1'b1;
        uart_tx(8'hA5);
        uart_tx(8'h01);
        uart_tx(8'h3F);
        uart_tx(8'h3E);
        repeat (5) tick();
        check("uart_valid", o_valid, 1);
        check("uart_len", o_len, 1);
        read_check("uart_rd0", 4'd0, 8'h3F);
        release_frame("uart_release");
        uart_mode = 1'b0;

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_cmd_parser
`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter SOF_BYTE, default 8'hA5: start-of-frame marker.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 3480 (40 bit times at CLKS_PER_BIT=87): maximum idle gap between bytes inside a frame.
REQ-004 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_Rx_DV, input, 1 bit: one-cycle byte-valid strobe from UART_RX o_Rx_DV.
REQ-007 SHALL have port i_Rx_Byte, input, 8 bits: received byte from UART_RX o_Rx_Byte.
REQ-008 SHALL have port o_Cmd_Valid, output, 1 bit: a complete frame is held and readable.
REQ-009 SHALL have port i_Cmd_Ready, input, 1 bit: the consumer releases the held frame.
REQ-010 SHALL have port o_Cmd_Len, output, 8 bits: payload length of the held frame.
REQ-011 SHALL have port i_Rd_Addr, input, $clog2(MAX_LEN) bits: payload read index.
REQ-012 SHALL have port o_Rd_Data, output, 8 bits: payload byte at i_Rd_Addr, combinational read.
REQ-013 SHALL have port o_Err_Pulse, output, 1 bit: one-cycle error strobe.
REQ-014 SHALL have port o_Err_Code, output, 2 bits: 00 timeout, 01 bad length, 10 checksum, 11 overrun; valid only while o_Err_Pulse is high.

Function
REQ-015 SHALL use frame format SOF, LEN, LEN payload bytes, CSUM; CSUM = XOR of LEN and all payload bytes.
REQ-016 SHALL implement the states IDLE, LEN, DATA, CSUM and HOLD, and act only on cycles where i_Rx_DV=1, except for timeout and handshake.
REQ-017 SHALL, in IDLE, move to LEN on a byte equal to SOF_BYTE and silently ignore every other byte.
REQ-018 SHALL, in LEN, on LEN=0 or LEN>MAX_LEN, pulse error 01 and return to IDLE; otherwise latch the length and move to DATA.
REQ-019 SHALL, in DATA, write each byte at index 0..LEN-1 and move to CSUM after byte LEN-1.
REQ-020 SHALL, in CSUM, move to HOLD on a match; on a mismatch it SHALL pulse error 10 and return to IDLE.
REQ-021 SHALL assert o_Cmd_Valid in the cycle after the edge that samples the final i_Rx_DV of a frame (one-cycle latency), holding o_Cmd_Len and the buffer stable.
REQ-022 SHALL, in HOLD, return to IDLE at the first edge where i_Cmd_Ready=1, deasserting o_Cmd_Valid in the next cycle.
REQ-023 SHALL, in HOLD with i_Cmd_Ready=0, drop any received byte and pulse error 11.
REQ-024 SHALL, when i_Cmd_Ready=1 and i_Rx_DV=1 fall in the same HOLD cycle, complete the handshake and process the byte as in IDLE, with no overrun; a SOF byte therefore moves the parser directly to LEN.
REQ-025 SHALL, in LEN/DATA/CSUM, clear the gap counter on each byte; on the counter reaching TIMEOUT_CLKS it SHALL pulse error 00 and return to IDLE.
REQ-026 SHALL NOT time out in IDLE or HOLD.
REQ-027 SHALL raise at most one error pulse per cycle.

Reset
REQ-028 SHALL, while i_Reset=0, force state IDLE, counters 0, o_Cmd_Valid=0, o_Cmd_Len=0, o_Err_Pulse=0 and o_Err_Code=00; payload buffer contents are not reset.
REQ-029 SHALL discard a partial frame on reset assertion mid-frame and raise no error.

Configuration
REQ-030 SHALL, with UART_CMD_CHECKSUM_EN defined, implement the CSUM state per REQ-020.
REQ-031 SHALL, with UART_CMD_CHECKSUM_EN undefined, have no CSUM byte in the frame, move DATA directly to HOLD after byte LEN-1, and never emit error code 10.

Structure
REQ-032 SHALL take the state encoding, the error-code constants and the default SOF value from shared package uart_cmd_pkg.
REQ-033 SHALL hold the payload storage in sub-module uart_cmd_buf (MAX_LEN x 8, one synchronous write port, one asynchronous read port).

Verification
REQ-034 SHALL cover a good frame: A5 03 11 22 33 03 -> o_Cmd_Valid=1, o_Cmd_Len=3, reads 11/22/33; i_Cmd_Ready=1 -> o_Cmd_Valid=0 next cycle.
REQ-035 SHALL cover a bad checksum: A5 03 11 22 33 04 -> o_Err_Pulse with code 10, no o_Cmd_Valid, state IDLE.
REQ-036 SHALL cover bad length: A5 00 -> code 01; A5 11 with MAX_LEN=16 -> code 01; then a good frame is still accepted.
REQ-037 SHALL cover timeout: A5 02 7E followed by no byte for TIMEOUT_CLKS cycles -> code 00; next byte 7F is ignored in IDLE.
REQ-038 SHALL cover overrun and simultaneity: while held, byte 55 with i_Cmd_Ready=0 -> code 11; byte A5 with i_Cmd_Ready=1 the same cycle -> no error, new frame A5 01 40 41 accepted.
REQ-039 SHALL cover full-path integration: UART_RX (CLKS_PER_BIT=87) serial-driving A5 01 3F 3E -> o_Cmd_Len=1, payload 3F.
